parking_entry_gate: RTL and testbench

PARKING_ENTRY_GATE -- requirements
Module: parking_entry_gate

---
 rtl/parking_pkg.sv | 23 ++
 rtl/parking_gate_timer.sv | 34 +++
 rtl/parking_entry_gate.sv | 187 ++++++++++++++++++
 tb/tb_parking_entry_gate.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the parking entry gate.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_REJECT  = 3'd4
    } gate_state_e;

    localparam int unsigned DEF_OPEN_TIMEOUT = 16;
    localparam int unsigned DEF_CLOSE_CYCLES = 4;
    localparam int unsigned STAT_W           = 16;

    // Bits needed to hold the larger of the two load values without wrapping.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/parking_gate_timer.sv
// Load/decrement/expire counter; holds at zero so it never wraps.
module parking_gate_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/parking_entry_gate.sv
// Parking barrier controller: admit/reject by class vacancy, open with timeout, timed close.
// Optional statistics counters are built when PARKING_GATE_STATS_EN is defined.
module parking_entry_gate
    import parking_pkg::*;
#(
    parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic car_present,
    input  logic uni_card,
    input  logic pass_sensor,
    input  logic is_vacated_space,
    input  logic uni_is_vacated_space,
    output logic gate_open,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic reject,
    output logic timeout
`ifdef PARKING_GATE_STATS_EN
    ,
    output logic [STAT_W-1:0] admit_count,
    output logic [STAT_W-1:0] reject_count,
    output logic [STAT_W-1:0] timeout_count
`endif
);

    localparam int unsigned TW = timer_width(OPEN_TIMEOUT, CLOSE_CYCLES);
    // The timer expires on its last count, so a dwell of N cycles loads N-1.
    localparam logic [TW-1:0] OPEN_LOAD  = (OPEN_TIMEOUT > 0) ? TW'(OPEN_TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] CLOSE_LOAD = (CLOSE_CYCLES > 0) ? TW'(CLOSE_CYCLES - 1) : '0;

    gate_state_e state_q, state_d;
    logic        car_prev_q, car_prev_d;
    logic        pass_prev_q, pass_prev_d;
    logic        armed_q, armed_d;
    logic        uni_lat_q, uni_lat_d;
    logic        is_uni_q, is_uni_d;
    logic        car_entered_q, car_entered_d;
    logic        timeout_q, timeout_d;

    logic          car_rise;
    logic          pass_rise;
    logic          class_vacant;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_expired;

    parking_gate_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // armed_q masks the first post-reset cycle so a level held through reset is not an edge.
    always_comb begin
        car_prev_d   = car_present;
        pass_prev_d  = pass_sensor;
        armed_d      = 1'b1;
        car_rise     = car_present & ~car_prev_q & armed_q;
        pass_rise    = pass_sensor & ~pass_prev_q;
        class_vacant = uni_lat_q ? uni_is_vacated_space : is_vacated_space;
    end

    always_comb begin
        state_d       = state_q;
        uni_lat_d     = uni_lat_q;
        is_uni_d      = is_uni_q;
        car_entered_d = 1'b0;
        timeout_d     = 1'b0;
        timer_load    = 1'b0;
        timer_val     = '0;

        case (state_q)
            ST_IDLE: begin
                if (car_rise) begin
                    state_d   = ST_CHECK;
                    uni_lat_d = uni_card;
                end
            end
            ST_CHECK: begin
                if (class_vacant) begin
                    state_d  = ST_OPEN;
                    is_uni_d = uni_lat_q;
                end else begin
                    state_d = ST_REJECT;
                end
            end
            ST_OPEN: begin
                // A pass edge wins over a simultaneous timer expiry.
                if (pass_rise) begin
                    state_d       = ST_CLOSING;
                    car_entered_d = 1'b1;
                end else if (timer_expired) begin
                    state_d   = ST_CLOSING;
                    timeout_d = 1'b1;
                end
            end
            ST_CLOSING: begin
                if (timer_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REJECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            timer_load = 1'b1;
            if (state_d == ST_OPEN) begin
                timer_val = OPEN_LOAD;
            end else if (state_d == ST_CLOSING) begin
                timer_val = CLOSE_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            car_prev_q    <= 1'b0;
            pass_prev_q   <= 1'b0;
            armed_q       <= 1'b0;
            uni_lat_q     <= 1'b0;
            is_uni_q      <= 1'b0;
            car_entered_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            car_prev_q    <= car_prev_d;
            pass_prev_q   <= pass_prev_d;
            armed_q       <= armed_d;
            uni_lat_q     <= uni_lat_d;
            is_uni_q      <= is_uni_d;
            car_entered_q <= car_entered_d;
            timeout_q     <= timeout_d;
        end
    end

    assign gate_open          = (state_q == ST_OPEN) || (state_q == ST_CLOSING);
    assign reject             = (state_q == ST_REJECT);
    assign car_entered        = car_entered_q;
    assign timeout            = timeout_q;
    assign is_uni_car_entered = is_uni_q;

`ifdef PARKING_GATE_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != {STAT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    logic [STAT_W-1:0] admit_cnt_q, admit_cnt_d;
    logic [STAT_W-1:0] reject_cnt_q, reject_cnt_d;
    logic [STAT_W-1:0] timeout_cnt_q, timeout_cnt_d;

    always_comb begin
        admit_cnt_d   = sat_inc(admit_cnt_q, car_entered_q);
        reject_cnt_d  = sat_inc(reject_cnt_q, reject);
        timeout_cnt_d = sat_inc(timeout_cnt_q, timeout_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            admit_cnt_q   <= '0;
            reject_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            admit_cnt_q   <= admit_cnt_d;
            reject_cnt_q  <= reject_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign admit_count   = admit_cnt_q;
    assign reject_count  = reject_cnt_q;
    assign timeout_count = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_parking_entry_gate.sv
// Bench for parking_entry_gate: directed scenarios plus randomized transactions checked
// against a transaction-level timing model (OPEN_TIMEOUT=8, CLOSE_CYCLES=4).
module tb_parking_entry_gate;

    localparam int T = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic car_present = 1'b0;
    logic uni_card = 1'b0;
    logic pass_sensor = 1'b0;
    logic is_vacated_space = 1'b0;
    logic uni_is_vacated_space = 1'b0;
    logic gate_open, car_entered, is_uni_car_entered, reject, timeout;
`ifdef PARKING_GATE_STATS_EN
    logic [15:0] admit_count, reject_count, timeout_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    bit exp_uni = 1'b0;
    int m_adm = 0;
    int m_rej = 0;
    int m_to = 0;

    always #5 clk = ~clk;

    parking_entry_gate #(
        .OPEN_TIMEOUT (T),
        .CLOSE_CYCLES (C)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .car_present          (car_present),
        .uni_card             (uni_card),
        .pass_sensor          (pass_sensor),
        .is_vacated_space     (is_vacated_space),
        .uni_is_vacated_space (uni_is_vacated_space),
        .gate_open            (gate_open),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .reject               (reject),
        .timeout              (timeout)
`ifdef PARKING_GATE_STATS_EN
        ,
        .admit_count          (admit_count),
        .reject_count         (reject_count),
        .timeout_count        (timeout_count)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk1({tag, ".gate"}, gate_open, 1'b0);
        chk1({tag, ".entered"}, car_entered, 1'b0);
        chk1({tag, ".reject"}, reject, 1'b0);
        chk1({tag, ".timeout"}, timeout, 1'b0);
        chk1({tag, ".uni"}, is_uni_car_entered, exp_uni);
    endtask

    task automatic idle_cycles(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            step();
            check_idle(tag);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef PARKING_GATE_STATS_EN
        chk16({tag, ".admits"}, admit_count, 16'(m_adm));
        chk16({tag, ".rejects"}, reject_count, 16'(m_rej));
        chk16({tag, ".timeouts"}, timeout_count, 16'(m_to));
`endif
    endtask

    // One car arrival. Edge n=0 samples the car_present rise, n=1 is the vacancy decision.
    // Admitted: gate high after edges 1..x+C-1 where x is the edge ending the open phase
    // (pass edge sampled at 1+d, or T+1 on timeout). Rejected: reject high after edge 1 only.
    // d in 1..T gives a pass edge; any other d means no pass.
    task automatic run_txn(input bit uni, input bit vr, input bit vu, input int d,
                           input int cp_hold, input bit keep);
        bit admit;
        bit pass;
        int x;
        int last;
        int m;
        admit = uni ? vu : vr;
        pass  = (d >= 1) && (d <= T);
        x     = pass ? (1 + d) : (T + 1);
        last  = admit ? (x + C) : 2;

        car_present          = 1'b1;
        uni_card             = uni;
        is_vacated_space     = vr;
        uni_is_vacated_space = vu;
        pass_sensor          = 1'b0;

        for (int n = 0; n <= last; n++) begin
            step();
            if (admit && n == 1) exp_uni = uni;
            chk1("gate_open", gate_open, admit && n >= 1 && n < x + C);
            chk1("car_entered", car_entered, admit && pass && n == x);
            chk1("timeout", timeout, admit && !pass && n == x);
            chk1("reject", reject, !admit && n == 1);
            chk1("is_uni_car_entered", is_uni_car_entered, exp_uni);

            if (n == 0) uni_card = 1'($urandom);
            if (n == 1) begin
                is_vacated_space     = 1'($urandom);
                uni_is_vacated_space = 1'($urandom);
            end
            m = n + 1;
            car_present = keep ? 1'b1 : ((m < cp_hold) || (m == cp_hold + 2 && m < last));
            // Second pulse lands in CLOSING and must be ignored.
            pass_sensor = admit && ((pass && (m == 1 + d || m == 2 + d)) || (m == x + 3 && C > 3));
        end

        if (!keep) car_present = 1'b0;
        pass_sensor = 1'b0;
        if (admit) begin
            if (pass) m_adm++;
            else m_to++;
        end else begin
            m_rej++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;
        idle_cycles(2, "post_reset");

        // Regular car admitted, pass 3 cycles after opening
        run_txn(1'b0, 1'b1, 1'b0, 3, 2, 1'b0);
        idle_cycles(2, "after_admit");
        // University car with no university space
        run_txn(1'b1, 1'b1, 1'b0, 0, 5, 1'b0);
        idle_cycles(2, "after_reject");
        // No pass: timeout
        run_txn(1'b0, 1'b1, 1'b1, 0, 4, 1'b0);
        idle_cycles(2, "after_timeout");
        // Pass edge on the expiry cycle
        run_txn(1'b0, 1'b1, 1'b0, T, 3, 1'b0);
        idle_cycles(2, "after_coincide");
        // University admit, then car_present held into IDLE must not retrigger
        run_txn(1'b1, 1'b0, 1'b1, 1, 20, 1'b1);
        idle_cycles(4, "held_level");
        car_present = 1'b0;
        idle_cycles(1, "held_release");
        // Regular car with no regular space
        run_txn(1'b0, 1'b0, 1'b1, 2, 1, 1'b0);
        idle_cycles(3, "after_reject2");
        check_stats("stats_directed");

        // Reset while open with a car under the barrier
        car_present          = 1'b1;
        uni_card             = 1'b1;
        uni_is_vacated_space = 1'b1;
        is_vacated_space     = 1'b0;
        step();
        chk1("rst_mid.check_gate", gate_open, 1'b0);
        step();
        chk1("rst_mid.open_gate", gate_open, 1'b1);
        chk1("rst_mid.open_uni", is_uni_car_entered, 1'b1);
        step();
        chk1("rst_mid.open_gate2", gate_open, 1'b1);
        rst         = 1'b1;
        pass_sensor = 1'b1;
        step();
        exp_uni = 1'b0;
        m_adm   = 0;
        m_rej   = 0;
        m_to    = 0;
        check_idle("rst_mid");
        rst = 1'b0;
        idle_cycles(5, "rst_held_car");
        car_present = 1'b0;
        pass_sensor = 1'b0;
        idle_cycles(2, "rst_release");
        check_stats("stats_after_rst");

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            bit r_keep;
            r_keep = ($urandom_range(0, 3) == 0);
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, T + 2)),
                    int'($urandom_range(1, 16)), r_keep);
            idle_cycles(int'($urandom_range(1, 3)), "rand_idle");
            if (r_keep) begin
                car_present = 1'b0;
                idle_cycles(1, "rand_release");
            end
        end
        idle_cycles(2, "final");
        check_stats("stats_random");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
